// File: rtl/mem_ctrl.sv
// Shared byte-wide RAM controller: arbitrates CPU fetch and load/store, serialising each access into byte beats.
// Optional macro MEM_CTRL_RR_EN selects round-robin arbitration instead of fixed data-over-inst priority.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_rdy_o,
  output logic [31:0]       inst_data_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [1:0]        data_size_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_rdy_o,
  output logic [31:0]       data_rdata_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [MEM_W-1:0]  mem_dout_o,
  output logic              mem_wr_o,
  input  logic [MEM_W-1:0]  mem_din_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          n_q, n_d;
  logic [2:0]          iss_q, iss_d;
  logic [2:0]          cap_q, cap_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic [31:0]         buf_q, buf_d;
  logic                is_data_q, is_data_d;
  logic [31:0]         inst_data_q, inst_data_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                data_first;
  logic                issue;
  logic [ADDR_W-1:0]   beat_addr;

`ifdef MEM_CTRL_RR_EN
  logic last_data_q, last_data_d;
  assign data_first = !last_data_q;
`else
  assign data_first = 1'b1;
`endif

  assign beat_addr    = addr_q + ADDR_W'(iss_q);
  assign busy_o       = (state_q != IDLE);
  assign inst_data_o  = inst_data_q;
  assign data_rdata_o = rdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    pipe_d      = pipe_q;
    buf_d       = buf_q;
    is_data_d   = is_data_q;
    inst_data_d = inst_data_q;
    rdata_d     = rdata_q;
`ifdef MEM_CTRL_RR_EN
    last_data_d = last_data_q;
`endif
    issue       = 1'b0;
    inst_rdy_o  = 1'b0;
    data_rdy_o  = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;

    case (state_q)
      IDLE: begin
        iss_d  = '0;
        cap_d  = '0;
        pipe_d = '0;
        buf_d  = '0;
        if (data_req_i && (!inst_req_i || data_first)) begin
          is_data_d = 1'b1;
          addr_d    = data_addr_i;
          wdata_d   = data_wdata_i;
          n_d       = (data_size_i == 2'd0) ? 3'd1 : (data_size_i == 2'd1) ? 3'd2 : 3'd4;
          state_d   = data_we_i ? DATA_WR : DATA_RD;
`ifdef MEM_CTRL_RR_EN
          last_data_d = 1'b1;
`endif
        end else if (inst_req_i) begin
          is_data_d = 1'b0;
          addr_d    = inst_addr_i;
          n_d       = 3'd4;
          state_d   = INST_RD;
`ifdef MEM_CTRL_RR_EN
          last_data_d = 1'b0;
`endif
        end
      end

      INST_RD, DATA_RD: begin
        // Address issue and byte capture run as independent pipelines RD_LAT apart.
        issue = (iss_q < n_q);
        if (issue) begin
          mem_a_o = beat_addr;
          iss_d   = iss_q + 3'd1;
        end
        pipe_d[0] = issue;
        for (int j = 1; j < RD_LAT; j++) pipe_d[j] = pipe_q[j-1];
        if (pipe_q[RD_LAT-1]) begin
          buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din_i;
          cap_d = cap_q + 3'd1;
          if (cap_q == n_q - 3'd1) begin
            state_d = DONE;
            if (is_data_q) rdata_d = buf_d;
            else           inst_data_d = buf_d;
          end
        end
      end

      DATA_WR: begin
        if (iss_q < n_q) begin
          mem_a_o    = beat_addr;
          mem_wr_o   = 1'b1;
          mem_dout_o = wdata_q[{iss_q[1:0], 3'b000} +: 8];
          iss_d      = iss_q + 3'd1;
          if (iss_q == n_q - 3'd1) state_d = DONE;
        end
      end

      DONE: begin
        inst_rdy_o = !is_data_q;
        data_rdy_o = is_data_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      pipe_q      <= '0;
      buf_q       <= '0;
      is_data_q   <= 1'b0;
      inst_data_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      pipe_q      <= pipe_d;
      buf_q       <= buf_d;
      is_data_q   <= is_data_d;
      inst_data_q <= inst_data_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MEM_CTRL_RR_EN
  // Data counts as last granted out of reset so inst wins the first tie.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) last_data_q <= 1'b1;
    else         last_data_q <= last_data_d;
  end
`endif

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Unified memory controller for the next-generation SoPC: the single-ROM instruction port becomes a shared byte-wide RAM bus that serves both CPU instruction fetch and CPU load/store.
- Arbitrates the two requesters and serialises each 1/2/4-byte access into byte beats on the memory bus.
- Assembles read bytes little-endian and returns them with a one-cycle ready pulse.
- Sits between the cpu and the ram instances in the top-level SoPC.

Parameters:
ADDR_W, 32, address width of requester ports and memory bus
MEM_W, 8, memory bus data width (fixed at 8; byte beats)
RD_LAT, 1, cycles from a read address being driven to its byte valid on mem_din_i (range 1..4)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset, asynchronous, active-low
inst_req_i  input  1  fetch request, held until inst_rdy_o
inst_addr_i  input  ADDR_W  fetch byte address (always 4-byte read)
inst_rdy_o  output  1  one-cycle completion pulse
inst_data_o  output  32  fetched word, held until next fetch completion
data_req_i  input  1  load/store request, held until data_rdy_o
data_we_i  input  1  1 = store, 0 = load
data_size_i  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
data_addr_i  input  ADDR_W  load/store byte address
data_wdata_i  input  32  store data; low bytes used
data_rdy_o  output  1  one-cycle completion pulse
data_rdata_o  output  32  load data, zero-extended, held until next load completion
mem_a_o  output  ADDR_W  memory byte address
mem_dout_o  output  8  memory write byte
mem_wr_o  output  1  write strobe for the current beat
mem_din_i  input  8  memory read byte
busy_o  output  1  high in any non-IDLE state

Behaviour:
- Reset values: all outputs 0; state IDLE; beat and capture counters 0.
- Reset is asynchronous at any time, including mid-transaction: the transaction is abandoned and no rdy is issued. A request still held after reset release is accepted afresh.
- States: IDLE, INST_RD, DATA_RD, DATA_WR, DONE.
- IDLE: at the edge ending cycle k, if a request is pending, the controller grants one requester, latches its address, size and write data, and sets beat count N (4 for fetch).
  - A requester whose rdy is high in the current cycle is ignored for that edge, so a stale held req is never re-accepted.
  - Fixed priority: data beats inst on simultaneous requests.
- Read states: byte i (0..N-1) address = latched addr + i (mod 2^ADDR_W), driven in cycle k+1+i, mem_wr_o=0.
  - The byte driven in cycle c is captured from mem_din_i at the end of cycle c+RD_LAT into result bits [8i+7:8i].
  - Issue and capture overlap (pipelined); counters track both independently.
- Read completion: after the last capture (end of cycle k+N+RD_LAT), enter DONE. rdy pulses in cycle k+N+RD_LAT+1 and the data output updates in that same cycle.
  - Load unused upper bytes are 0.
- DATA_WR: byte i = data_wdata_i[8i+7:8i], driven with mem_wr_o=1 in cycle k+1+i; DONE follows, so data_rdy_o pulses in cycle k+N+1.
- DONE: one cycle; assert the granted rdy; return to IDLE. A different pending requester may be accepted at the DONE→IDLE edge + 1, i.e. from IDLE only (one idle cycle minimum between transactions).
- Outside active beats: mem_wr_o=0, mem_a_o=0, mem_dout_o=0.
- No alignment requirement: misaligned and wrap-around addresses are serviced byte-wise.
- Request inputs are not re-sampled once granted; changes to address or data mid-transaction are ignored.

Optional Feature:
MEM_CTRL_RR_EN
- Defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. After reset, data is treated as last granted, so inst wins the first tie.
- Undefined: fixed data-over-inst priority as above.
- No other behaviour differs.

Test Plan:
1. Reset release, inst_req_i=1, addr=0x100, memory holds 0x13,0x05,0x10,0x00 at 0x100..0x103, RD_LAT=1 → mem_a_o 0x100..0x103 on cycles k+1..k+4; inst_rdy_o pulses at k+6; inst_data_o=0x00100513.
2. Store word 0xDEADBEEF to 0x200 → mem_wr_o high 4 cycles with bytes EF,BE,AD,DE at 0x200..0x203; data_rdy_o at k+5; load size=1 from 0x202 → data_rdata_o=0x0000DEAD.
3. inst and data requests rise in the same cycle → data serviced first, inst granted after DONE+IDLE; with MEM_CTRL_RR_EN, inst first, then data.
4. Load byte at addr 0xFFFFFFFF, size=2 → addresses 0xFFFFFFFF,0x0,0x1,0x2; byte order correct.
5. Assert rst_in low during beat 2 of a fetch → all outputs 0 immediately, no inst_rdy_o; req still high after release → full fetch restarts from beat 0.
6. RD_LAT=3 fetch → inst_rdy_o at k+8; captured word matches memory; requester held req during rdy cycle is not re-accepted.
